// File: rtl/snake_ctrl.sv
// snake_ctrl: game-state controller for the Snake datapath.
// Holds the snake body in a ring buffer, advances it on a programmable tick,
// applies direction rules, growth, wall and self-collision, and serves body
// segments to the renderer through a registered read port.
// Optional feature: define SNAKE_WRAP_EN to make the walls wrap around.
module snake_ctrl #(
  parameter int GRID_W   = 40,
  parameter int GRID_H   = 30,
  parameter int MAX_LEN  = 64,
  parameter int TICK_DIV = 6250000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] move,
  input  logic       start,
  input  logic [5:0] food_x,
  input  logic [4:0] food_y,
  input  logic [5:0] rd_idx,
  output logic [5:0] rd_x,
  output logic [4:0] rd_y,
  output logic       rd_valid,
  output logic [5:0] head_x,
  output logic [4:0] head_y,
  output logic [6:0] length,
  output logic       running,
  output logic       dead,
  output logic       ate,
  output logic       step
);
  localparam int          PW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [5:0]  X_MAX     = 6'(GRID_W - 1);
  localparam logic [4:0]  Y_MAX     = 5'(GRID_H - 1);
  localparam logic [5:0]  X_MID     = 6'(GRID_W / 2);
  localparam logic [4:0]  Y_MID     = 5'(GRID_H / 2);
  localparam logic [6:0]  LEN_MAX   = 7'(MAX_LEN);
  localparam logic [31:0] TICK_LAST = 32'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_IDLE   = 3'd1,
    S_RUN    = 3'd2,
    S_STEP   = 3'd3,
    S_SCAN   = 3'd4,
    S_COMMIT = 3'd5,
    S_DEAD   = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  // Opposite directions differ only in the low bit.
  function automatic dir_t opposite(input dir_t d);
    return dir_t'({d[1], ~d[0]});
  endfunction

  state_t        state_r, state_s;
  logic [1:0]    init_cnt_r;
  logic          go_run_r;
  logic [31:0]   tick_r;
  dir_t          dir_r, pending_dir_r;
  logic [PW-1:0] hp_r, scan_k_r;
  logic [5:0]    new_x_r, head_x_r, rd_x_r;
  logic [4:0]    new_y_r, head_y_r, rd_y_r;
  logic          grow_r, rd_valid_r, running_r, dead_r, ate_r, step_r;
  logic [6:0]    length_r;
  logic [5:0]    mem_x [MAX_LEN];
  logic [4:0]    mem_y [MAX_LEN];

  logic [5:0]    nx_s;
  logic [4:0]    ny_s;
  logic          wall_s, grow_s, mv_valid_s, scan_hit_s, scan_done_s;
  dir_t          mv_dir_s, ref_dir_s;
  logic [6:0]    scan_last_s;
  logic [PW-1:0] scan_addr_s, rd_addr_s, commit_addr_s, init_addr_s;

  // Decode the keyboard code; move 1..4 maps to (move-1) in the low two bits.
  always_comb begin
    mv_valid_s = (move >= 3'd1) && (move <= 3'd4);
    mv_dir_s   = dir_t'(move[1:0] - 2'd1);
    // In STEP the pending direction is about to become committed.
    if (state_r == S_STEP) begin
      ref_dir_s = pending_dir_r;
    end else begin
      ref_dir_s = dir_r;
    end
  end

  // Candidate new head from the committed head and the pending direction.
  always_comb begin
    nx_s   = head_x_r;
    ny_s   = head_y_r;
    wall_s = 1'b0;
    case (pending_dir_r)
      DIR_UP: begin
        if (head_y_r == 5'd0) begin
`ifdef SNAKE_WRAP_EN
          ny_s = Y_MAX;
`else
          wall_s = 1'b1;
`endif
        end else begin
          ny_s = head_y_r - 5'd1;
        end
      end
      DIR_DOWN: begin
        if (head_y_r == Y_MAX) begin
`ifdef SNAKE_WRAP_EN
          ny_s = 5'd0;
`else
          wall_s = 1'b1;
`endif
        end else begin
          ny_s = head_y_r + 5'd1;
        end
      end
      DIR_LEFT: begin
        if (head_x_r == 6'd0) begin
`ifdef SNAKE_WRAP_EN
          nx_s = X_MAX;
`else
          wall_s = 1'b1;
`endif
        end else begin
          nx_s = head_x_r - 6'd1;
        end
      end
      DIR_RIGHT: begin
        if (head_x_r == X_MAX) begin
`ifdef SNAKE_WRAP_EN
          nx_s = 6'd0;
`else
          wall_s = 1'b1;
`endif
        end else begin
          nx_s = head_x_r + 6'd1;
        end
      end
      default: begin
        wall_s = 1'b1;
      end
    endcase
    grow_s = (nx_s == food_x) && (ny_s == food_y);
  end

  // Ring-buffer addressing and the internal self-collision read path.
  always_comb begin
    init_addr_s   = PW'(init_cnt_r);
    commit_addr_s = hp_r + PW'(1);
    scan_addr_s   = hp_r - scan_k_r;
    rd_addr_s     = hp_r - rd_idx[PW-1:0];
    scan_hit_s    = (mem_x[scan_addr_s] == new_x_r) && (mem_y[scan_addr_s] == new_y_r);
    // The tail moves away this step unless the snake grows, so skip it.
    if (grow_r) begin
      scan_last_s = length_r - 7'd1;
    end else begin
      scan_last_s = length_r - 7'd2;
    end
    scan_done_s = (7'(scan_k_r) == scan_last_s);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_INIT;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_INIT: begin
        if (init_cnt_r == 2'd2) begin
          state_s = go_run_r ? S_RUN : S_IDLE;
        end else begin
          state_s = S_INIT;
        end
      end
      S_IDLE, S_DEAD: begin
        if (start) begin
          state_s = S_INIT;
        end else begin
          state_s = state_r;
        end
      end
      S_RUN: begin
        if (tick_r == TICK_LAST) begin
          state_s = S_STEP;
        end else begin
          state_s = S_RUN;
        end
      end
      S_STEP: begin
        state_s = wall_s ? S_DEAD : S_SCAN;
      end
      S_SCAN: begin
        if (scan_hit_s) begin
          state_s = S_DEAD;
        end else if (scan_done_s) begin
          state_s = S_COMMIT;
        end else begin
          state_s = S_SCAN;
        end
      end
      S_COMMIT: begin
        state_s = S_RUN;
      end
      default: begin
        state_s = S_INIT;
      end
    endcase
  end

  // Game state, direction, tick counter and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      init_cnt_r    <= 2'd0;
      go_run_r      <= 1'b0;
      tick_r        <= 32'd0;
      dir_r         <= DIR_RIGHT;
      pending_dir_r <= DIR_RIGHT;
      hp_r          <= PW'(0);
      scan_k_r      <= PW'(0);
      new_x_r       <= 6'd0;
      new_y_r       <= 5'd0;
      grow_r        <= 1'b0;
      head_x_r      <= 6'd0;
      head_y_r      <= 5'd0;
      length_r      <= 7'd0;
      running_r     <= 1'b0;
      dead_r        <= 1'b0;
      ate_r         <= 1'b0;
      step_r        <= 1'b0;
    end else begin
      running_r  <= (state_s == S_RUN) || (state_s == S_STEP) ||
                    (state_s == S_SCAN) || (state_s == S_COMMIT);
      dead_r     <= (state_s == S_DEAD);
      step_r     <= (state_s == S_COMMIT);
      ate_r      <= (state_s == S_COMMIT) && grow_r;
      tick_r     <= ((state_r == S_RUN) && (tick_r != TICK_LAST)) ? tick_r + 32'd1 : 32'd0;
      init_cnt_r <= (state_r == S_INIT) ? init_cnt_r + 2'd1 : 2'd0;
      if (((state_r == S_IDLE) || (state_r == S_DEAD)) && start) begin
        go_run_r <= 1'b1;
      end
      if (state_r == S_INIT) begin
        dir_r         <= DIR_RIGHT;
        pending_dir_r <= DIR_RIGHT;
      end else begin
        if (state_r == S_STEP) begin
          dir_r <= pending_dir_r;
        end
        if (mv_valid_s && (mv_dir_s != opposite(ref_dir_s))) begin
          pending_dir_r <= mv_dir_s;
        end
      end
      if (state_r == S_STEP) begin
        new_x_r  <= nx_s;
        new_y_r  <= ny_s;
        grow_r   <= grow_s;
        scan_k_r <= PW'(0);
      end else if (state_r == S_SCAN) begin
        scan_k_r <= scan_k_r + PW'(1);
      end
      if ((state_r == S_INIT) && (init_cnt_r == 2'd2)) begin
        head_x_r <= X_MID;
        head_y_r <= Y_MID;
        length_r <= 7'd3;
        hp_r     <= PW'(2);
      end else if (state_r == S_COMMIT) begin
        hp_r     <= commit_addr_s;
        head_x_r <= new_x_r;
        head_y_r <= new_y_r;
        // At full length the oldest cell is overwritten, so the tail drops.
        if (grow_r && (length_r < LEN_MAX)) begin
          length_r <= length_r + 7'd1;
        end
      end
    end
  end

  // Body storage: INIT lays down the starting snake, COMMIT pushes the new head.
  always_ff @(posedge clk) begin
    if (!rst && (state_r == S_INIT)) begin
      mem_x[init_addr_s] <= X_MID - 6'd2 + 6'(init_cnt_r);
      mem_y[init_addr_s] <= Y_MID;
    end else if (!rst && (state_r == S_COMMIT)) begin
      mem_x[commit_addr_s] <= new_x_r;
      mem_y[commit_addr_s] <= new_y_r;
    end
  end

  // Renderer read port; held at zero while the buffer is being initialised.
  always_ff @(posedge clk) begin
    if (rst || (state_r == S_INIT)) begin
      rd_x_r     <= 6'd0;
      rd_y_r     <= 5'd0;
      rd_valid_r <= 1'b0;
    end else begin
      rd_x_r     <= mem_x[rd_addr_s];
      rd_y_r     <= mem_y[rd_addr_s];
      rd_valid_r <= ({1'b0, rd_idx} < length_r);
    end
  end

  assign rd_x     = rd_x_r;
  assign rd_y     = rd_y_r;
  assign rd_valid = rd_valid_r;
  assign head_x   = head_x_r;
  assign head_y   = head_y_r;
  assign length   = length_r;
  assign running  = running_r;
  assign dead     = dead_r;
  assign ate      = ate_r;
  assign step     = step_r;

endmodule

// File: tb/tb_snake_ctrl.sv
// tb_snake_ctrl: scenario bench for snake_ctrl with a short game tick.
module tb_snake_ctrl;
  logic       clk = 1'b0;
  logic       rst, start;
  logic [2:0] move;
  logic [5:0] food_x, rd_idx;
  logic [4:0] food_y;
  logic [5:0] rd_x, head_x;
  logic [4:0] rd_y, head_y;
  logic       rd_valid, running, dead, ate, step;
  logic [6:0] length;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       st;
    logic [2:0] mv;
    logic [5:0] x;
    logic [4:0] y;
    logic [6:0] len;
    logic       ate;
  } item_t;

  item_t exp_q[$];

  snake_ctrl #(.GRID_W(40), .GRID_H(30), .MAX_LEN(64), .TICK_DIV(16)) dut (
    .clk(clk), .rst(rst), .move(move), .start(start),
    .food_x(food_x), .food_y(food_y), .rd_idx(rd_idx),
    .rd_x(rd_x), .rd_y(rd_y), .rd_valid(rd_valid),
    .head_x(head_x), .head_y(head_y), .length(length),
    .running(running), .dead(dead), .ate(ate), .step(step)
  );

  always #5 clk = ~clk;

  // Wait (bounded) for a step pulse, then one more cycle so committed values are visible.
  task automatic wait_step(input int budget, output bit got, output logic ate_seen, output logic after);
    got = 1'b0; ate_seen = 1'b0; after = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (step === 1'b1) begin
        got = 1'b1;
        ate_seen = ate;
        break;
      end
    end
    if (got) begin
      @(negedge clk);
      after = step | ate;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; move = 3'd0; food_x = 6'd0; food_y = 5'd0; rd_idx = 6'd0;
    repeat (3) @(negedge clk);
    total++;
    if ({running, dead, ate, step, rd_valid, rd_x, rd_y, head_x, head_y, length} !== 29'd0) begin
      bad++;
      $display("FAIL reset_outputs: run=%0b dead=%0b ate=%0b step=%0b rv=%0b rd=(%0d,%0d) head=(%0d,%0d) len=%0d, all must be 0",
               running, dead, ate, step, rd_valid, rd_x, rd_y, head_x, head_y, length);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (length !== 7'd0) begin
      bad++; $display("FAIL init_pending: len=%0d want 0", length);
    end
    @(negedge clk);
    total++;
    if (length !== 7'd3 || head_x !== 6'd20 || head_y !== 5'd15 || running !== 1'b0 || dead !== 1'b0) begin
      bad++;
      $display("FAIL init_done: len=%0d head=(%0d,%0d) run=%0b dead=%0b want len=3 head=(20,15) run=0 dead=0",
               length, head_x, head_y, running, dead);
    end
    rd_idx = 6'd0;
    @(negedge clk);
    total++;
    if (rd_x !== 6'd20 || rd_y !== 5'd15 || rd_valid !== 1'b1) begin
      bad++; $display("FAIL rd_seg0: (%0d,%0d) v=%0b want (20,15) v=1", rd_x, rd_y, rd_valid);
    end
    rd_idx = 6'd2;
    @(negedge clk);
    total++;
    if (rd_x !== 6'd18 || rd_y !== 5'd15 || rd_valid !== 1'b1) begin
      bad++; $display("FAIL rd_seg2_init: (%0d,%0d) v=%0b want (18,15) v=1", rd_x, rd_y, rd_valid);
    end
    rd_idx = 6'd3;
    @(negedge clk);
    total++;
    if (rd_valid !== 1'b0) begin
      bad++; $display("FAIL rd_seg3_invalid: v=%0b want 0", rd_valid);
    end
  endtask

  task automatic test_first_step();
    bit got; logic a, sa; item_t e;
    food_x = 6'd0; food_y = 5'd0;
    exp_q.push_back('{1'b1, 3'd0, 6'd21, 5'd15, 7'd3, 1'b0});
    while (exp_q.size() > 0) begin
      start = exp_q[0].st; move = exp_q[0].mv;
      @(negedge clk);
      start = 1'b0; move = 3'd0;
      wait_step(200, got, a, sa);
      e = exp_q.pop_front();
      total++;
      if (!got || a !== e.ate || sa !== 1'b0 || head_x !== e.x || head_y !== e.y || length !== e.len || running !== 1'b1) begin
        bad++;
        $display("FAIL first_step: seen=%0b ate=%0b after=%0b head=(%0d,%0d) len=%0d run=%0b want ate=%0b head=(%0d,%0d) len=%0d run=1",
                 got, a, sa, head_x, head_y, length, running, e.ate, e.x, e.y, e.len);
      end
    end
    rd_idx = 6'd2;
    @(negedge clk);
    total++;
    if (rd_x !== 6'd19 || rd_y !== 5'd15 || rd_valid !== 1'b1) begin
      bad++; $display("FAIL rd_seg2_step: (%0d,%0d) v=%0b want (19,15) v=1", rd_x, rd_y, rd_valid);
    end
  endtask

  task automatic test_direction();
    bit got; logic a, sa; item_t e;
    exp_q.push_back('{1'b0, 3'd3, 6'd22, 5'd15, 7'd3, 1'b0}); // reverse: ignored
    exp_q.push_back('{1'b0, 3'd1, 6'd22, 5'd14, 7'd3, 1'b0}); // up
    exp_q.push_back('{1'b0, 3'd6, 6'd22, 5'd13, 7'd3, 1'b0}); // code 6: ignored
    exp_q.push_back('{1'b0, 3'd2, 6'd22, 5'd12, 7'd3, 1'b0}); // reverse of up: ignored
    while (exp_q.size() > 0) begin
      start = exp_q[0].st; move = exp_q[0].mv;
      @(negedge clk);
      start = 1'b0; move = 3'd0;
      wait_step(200, got, a, sa);
      e = exp_q.pop_front();
      total++;
      if (!got || a !== e.ate || sa !== 1'b0 || head_x !== e.x || head_y !== e.y || length !== e.len) begin
        bad++;
        $display("FAIL direction_step mv=%0d: seen=%0b ate=%0b after=%0b head=(%0d,%0d) len=%0d want ate=%0b head=(%0d,%0d) len=%0d",
                 e.mv, got, a, sa, head_x, head_y, length, e.ate, e.x, e.y, e.len);
      end
    end
  endtask

  task automatic test_rst_mid_scan();
    bit got; logic a, sa; item_t e;
    logic seen;
    exp_q.push_back('{1'b0, 3'd0, 6'd22, 5'd11, 7'd3, 1'b0});
    start = exp_q[0].st; move = exp_q[0].mv;
    @(negedge clk);
    start = 1'b0; move = 3'd0;
    wait_step(200, got, a, sa);
    e = exp_q.pop_front();
    total++;
    if (!got || head_x !== e.x || head_y !== e.y || length !== e.len) begin
      bad++;
      $display("FAIL pre_rst_step: seen=%0b head=(%0d,%0d) len=%0d want head=(%0d,%0d) len=%0d",
               got, head_x, head_y, length, e.x, e.y, e.len);
    end
    // 16 RUN cycles, then STEP, then the first SCAN cycle.
    seen = 1'b0;
    for (int c = 0; c < 17; c++) begin
      @(negedge clk);
      if (step === 1'b1) seen = 1'b1;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (seen !== 1'b0 || step !== 1'b0 || running !== 1'b0 || length !== 7'd0 || head_x !== 6'd0) begin
      bad++;
      $display("FAIL rst_in_scan: early_step=%0b step=%0b run=%0b len=%0d hx=%0d want 0 0 0 0 0",
               seen, step, running, length, head_x);
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (step === 1'b1) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0 || length !== 7'd3 || head_x !== 6'd20 || head_y !== 5'd15 || running !== 1'b0 || dead !== 1'b0) begin
      bad++;
      $display("FAIL after_rst_idle: step_seen=%0b len=%0d head=(%0d,%0d) run=%0b dead=%0b want 0 3 (20,15) 0 0",
               seen, length, head_x, head_y, running, dead);
    end
  endtask

  task automatic test_grow();
    bit got; logic a, sa; item_t e;
    food_x = 6'd21; food_y = 5'd15;
    exp_q.push_back('{1'b1, 3'd0, 6'd21, 5'd15, 7'd4, 1'b1});
    while (exp_q.size() > 0) begin
      start = exp_q[0].st; move = exp_q[0].mv;
      @(negedge clk);
      start = 1'b0; move = 3'd0;
      wait_step(200, got, a, sa);
      e = exp_q.pop_front();
      total++;
      if (!got || a !== e.ate || sa !== 1'b0 || head_x !== e.x || head_y !== e.y || length !== e.len) begin
        bad++;
        $display("FAIL grow_step: seen=%0b ate=%0b after=%0b head=(%0d,%0d) len=%0d want ate=%0b head=(%0d,%0d) len=%0d",
                 got, a, sa, head_x, head_y, length, e.ate, e.x, e.y, e.len);
      end
    end
    rd_idx = 6'd3;
    @(negedge clk);
    total++;
    if (rd_x !== 6'd18 || rd_y !== 5'd15 || rd_valid !== 1'b1) begin
      bad++; $display("FAIL rd_tail_grown: (%0d,%0d) v=%0b want (18,15) v=1", rd_x, rd_y, rd_valid);
    end
    rd_idx = 6'd4;
    @(negedge clk);
    total++;
    if (rd_valid !== 1'b0) begin
      bad++; $display("FAIL rd_past_tail: v=%0b want 0", rd_valid);
    end
  endtask

  task automatic test_self_collision();
    bit got; logic a, sa; item_t e;
    logic seen;
    food_x = 6'd22; food_y = 5'd15;
    exp_q.push_back('{1'b0, 3'd0, 6'd22, 5'd15, 7'd5, 1'b1});
    exp_q.push_back('{1'b0, 3'd1, 6'd22, 5'd14, 7'd5, 1'b0});
    exp_q.push_back('{1'b0, 3'd3, 6'd21, 5'd14, 7'd5, 1'b0});
    while (exp_q.size() > 0) begin
      start = exp_q[0].st; move = exp_q[0].mv;
      @(negedge clk);
      start = 1'b0; move = 3'd0;
      wait_step(200, got, a, sa);
      e = exp_q.pop_front();
      total++;
      if (!got || a !== e.ate || sa !== 1'b0 || head_x !== e.x || head_y !== e.y || length !== e.len) begin
        bad++;
        $display("FAIL coil_step mv=%0d: seen=%0b ate=%0b after=%0b head=(%0d,%0d) len=%0d want ate=%0b head=(%0d,%0d) len=%0d",
                 e.mv, got, a, sa, head_x, head_y, length, e.ate, e.x, e.y, e.len);
      end
    end
    move = 3'd2;
    @(negedge clk);
    move = 3'd0;
    got = 1'b0; seen = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (step === 1'b1) seen = 1'b1;
      if (dead === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    total++;
    if (!got || seen !== 1'b0 || running !== 1'b0 || length !== 7'd5 || head_x !== 6'd21 || head_y !== 5'd14) begin
      bad++;
      $display("FAIL self_hit: dead=%0b step_seen=%0b run=%0b len=%0d head=(%0d,%0d) want 1 0 0 5 (21,14)",
               got, seen, running, length, head_x, head_y);
    end
  endtask

  task automatic test_wall();
    bit got; logic a, sa; item_t e;
    logic seen;
    food_x = 6'd0; food_y = 5'd0;
    for (int x = 21; x <= 39; x++) begin
      // A start pulse mid-game must not disturb the run.
      exp_q.push_back('{(x == 25), 3'd0, 6'(x), 5'd15, 7'd3, 1'b0});
    end
`ifdef SNAKE_WRAP_EN
    exp_q.push_back('{1'b0, 3'd0, 6'd0, 5'd15, 7'd3, 1'b0});
`endif
    // The first entry restarts the game from DEAD.
    exp_q[0].st = 1'b1;
    while (exp_q.size() > 0) begin
      start = exp_q[0].st; move = exp_q[0].mv;
      @(negedge clk);
      start = 1'b0; move = 3'd0;
      wait_step(200, got, a, sa);
      e = exp_q.pop_front();
      total++;
      if (!got || a !== e.ate || sa !== 1'b0 || head_x !== e.x || head_y !== e.y || length !== e.len) begin
        bad++;
        $display("FAIL wall_run_step: seen=%0b ate=%0b after=%0b head=(%0d,%0d) len=%0d want ate=%0b head=(%0d,%0d) len=%0d",
                 got, a, sa, head_x, head_y, length, e.ate, e.x, e.y, e.len);
      end
    end
`ifndef SNAKE_WRAP_EN
    got = 1'b0; seen = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (step === 1'b1) seen = 1'b1;
      if (dead === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    total++;
    if (!got || seen !== 1'b0 || running !== 1'b0 || head_x !== 6'd39 || head_y !== 5'd15 || length !== 7'd3) begin
      bad++;
      $display("FAIL wall_hit: dead=%0b step_seen=%0b run=%0b head=(%0d,%0d) len=%0d want 1 0 0 (39,15) 3",
               got, seen, running, head_x, head_y, length);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_first_step();
    test_direction();
    test_rst_mid_scan();
    test_grow();
    test_self_collision();
    test_wall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/snake_ctrl.md
# snake_ctrl

Game-state controller for the Snake datapath. It sits between the keyboard decoder's 3-bit `move` code and the VGA renderer. It owns the snake body as a ring buffer of grid cells, advances the snake on a programmable game tick, applies direction rules, growth and collisions, and serves body segments to the renderer through a registered read port. The renderer only draws; every sequencing decision lives here.

## Interface
Parameters:
- `GRID_W`, default 40: grid columns (16-px cells on 640x480). Must be ≤64.
- `GRID_H`, default 30: grid rows. Must be ≤32.
- `MAX_LEN`, default 64: ring-buffer depth. Power of two, ≤64.
- `TICK_DIV`, default 6250000: clk cycles per game step. Must be ≥ MAX_LEN+8.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `move`  in  3  decoder code: 0 none, 1 up, 2 down, 3 left, 4 right, 5–7 ignored.
- `start`  in  1  level/pulse; begins a new game from IDLE or DEAD.
- `food_x`  in  6  food column.
- `food_y`  in  5  food row.
- `rd_idx`  in  6  segment index, 0 = head.
- `rd_x`  out  6  column of segment `rd_idx`.
- `rd_y`  out  5  row of segment `rd_idx`.
- `rd_valid`  out  1  `rd_idx` < `length`.
- `head_x`  out  6  committed head column.
- `head_y`  out  5  committed head row.
- `length`  out  7  committed length.
- `running`  out  1  high in RUN/STEP/SCAN/COMMIT.
- `dead`  out  1  high in DEAD.
- `ate`  out  1  one-cycle pulse on a growth commit.
- `step`  out  1  one-cycle pulse on every commit.

## Operation
- States: INIT, IDLE, RUN, STEP, SCAN, COMMIT, DEAD.
- INIT (3 cycles):
  - Writes segments (GRID_W/2, GRID_H/2), (x−1), (x−2).
  - Sets `length`=3, dir=right, pending_dir=right, head pointer hp=2.
  - Exits to IDLE after reset, or to RUN when entered via `start`.
- IDLE/DEAD: `start`=1 → INIT. All other inputs are ignored except `move`.
- RUN:
  - Tick counter counts 0..TICK_DIV−1. It is cleared on entering RUN.
  - At terminal count → STEP.
- Direction:
  - Valid `move` (1–4) loads pending_dir in any state, unless it is the opposite of committed dir. Same-as-dir is accepted with no effect.
  - `move`=0 or 5–7 leaves pending_dir unchanged.
- STEP (1 cycle):
  - dir ← pending_dir.
  - new head = head ± 1 on one axis.
  - grow = (new head == food).
  - Wall check: x ≥ GRID_W, y ≥ GRID_H, or underflow → DEAD, no commit.
  - Otherwise → SCAN.
- SCAN:
  - Compares new head against segment k, one per cycle, for k = 0..length−1.
  - Skips the tail (k = length−1) unless grow.
  - Any match → DEAD immediately. Completion → COMMIT.
- COMMIT (1 cycle):
  - hp ← hp+1 mod MAX_LEN; mem[hp+1] ← new head; head_x/head_y updated.
  - If grow and `length` < MAX_LEN: `length`+1.
  - If grow at MAX_LEN: length saturates, the tail drops, `ate` still pulses.
  - `step`=1; `ate`=grow. Next state RUN.
- Storage: segment k lives at mem[(hp−k) mod MAX_LEN].
- Read port:
  - rd_x/rd_y/rd_valid are registered from mem[(hp−rd_idx)] and reflect committed state only.
  - SCAN uses an internal read path and never disturbs the read port.
- Reset values:
  - `running`, `dead`, `ate`, `step`, `rd_valid` = 0.
  - `rd_x`, `rd_y`, `head_x`, `head_y`, `length` = 0 until INIT completes.
  - Tick counter = 0; state = INIT.

## Timing
- Read port latency: 1 cycle from `rd_idx` to `rd_x`/`rd_y`/`rd_valid`.
- Step latency: STEP → COMMIT = 1 + (cells scanned) cycles. Maximum is MAX_LEN+1.
- `step`/`ate` are high for exactly the COMMIT cycle.
- `head_x`/`head_y`/`length` change on the edge ending COMMIT.
- `move` sampled in the STEP cycle goes to pending_dir and applies at the next step.
- `rst` in any state, including mid-SCAN: aborts with no partial commit. Next cycle is INIT with reset outputs.
- `start` while running: ignored.

## Configuration
- `SNAKE_WRAP_EN` defined: walls wrap.
  - x = GRID_W → 0; x underflow → GRID_W−1; same for y with GRID_H.
  - The wall check never kills; only self-collision does.
- `SNAKE_WRAP_EN` undefined: leaving the grid → DEAD, with head unchanged.

## Test plan
- `TICK_DIV`=16, reset, `start` pulse, no `move` → after first `step`: head (21,15), `length`=3, segment 2 reads (19,15) one cycle after `rd_idx`=2.
- dir right, `move`=3 (left) → ignored, head (22,15). Then `move`=1 → next head (22,14).
- food (21,15), `start` → first COMMIT: `ate`=1 for 1 cycle, `length`=4, `rd_idx`=3 → (18,15), `rd_valid`=1. `rd_idx`=4 → `rd_valid`=0.
- Run right to x=39, then one more step:
  - Without macro: `dead`=1, `running`=0, head stays (39,15), no `step` pulse.
  - With `SNAKE_WRAP_EN`: head (0,15).
- Grow to `length`=5, then `move` up, left, down on successive steps → third step: `dead`=1 and `length` still 5.
- Assert `rst` during SCAN → no `step`, INIT then IDLE, `length`=3, head (20,15), `running`=0.
